// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and defaults for the SRAM access controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Access sequencing states: one idle state, two half-word phases, one
    // single-cycle completion state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned c_DEFAULT_WAIT_CYCLES = 5;
    localparam logic [31:0] c_DEFAULT_BASE_ADDR   = 32'd1024;

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : wait_counter
// Purpose  : Modulo-WAIT_CYCLES phase counter. Flags the last cycle of a
//            phase and the cycle just before it (used to time the write
//            strobe release one cycle ahead, since the strobe is registered).
// Revision : 1.0 - initial release
// ============================================================================
module wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5,
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last,
    output logic next_last
);

    localparam logic [CW-1:0] c_LAST   = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] c_PENULT = CW'(WAIT_CYCLES - 2);

    logic [CW-1:0] r_count;

    // Count while enabled, wrapping to zero after the last phase cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= last ? '0 : r_count + 1'b1;
        end
    end

    assign last      = en && (r_count == c_LAST);
    assign next_last = en && (r_count == c_PENULT);

endmodule
`default_nettype wire

// File: rtl/sram_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_controller
// Purpose  : Splits 32-bit LDR/STR accesses into two 16-bit SRAM phases with
//            programmable wait states, stalling the pipeline via ready.
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = c_DEFAULT_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = 18,
    parameter logic [31:0] BASE_ADDR   = c_DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned c_IDX_W = SRAM_AW - 1;

    state_t               r_state;
    state_t               w_next_state;

    logic                 r_write;
    logic [c_IDX_W-1:0]   r_idx;
    logic [31:0]          r_wdata;

    logic                 w_req;
    logic                 w_req_write;
    logic [31:0]          w_offset;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_unused_offset_bits;

    logic                 w_cnt_clear;
    logic                 w_cnt_en;
    logic                 w_last;
    logic                 w_next_last;

    logic                 w_capture;
    logic                 w_lat_lo;
    logic                 w_lat_hi;
    logic [SRAM_AW-1:0]   w_addr_nxt;
    logic [15:0]          w_dq_out_nxt;
    logic                 w_oe_nxt;
    logic                 w_we_n_nxt;

    // Both enables high is treated as a store.
    assign w_req       = mem_r_en | mem_w_en;
    assign w_req_write = mem_w_en;

    // Word index relative to the SRAM window; wraps silently when out of range.
    assign w_offset = addr - BASE_ADDR;
    assign w_idx    = w_offset[c_IDX_W+1:2];
    assign w_unused_offset_bits = &{1'b0, w_offset[31:c_IDX_W+2], w_offset[1:0]};

    wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_cnt_clear),
        .en        (w_cnt_en),
        .last      (w_last),
        .next_last (w_next_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: each phase ends on the counter's last cycle; DONE
    // always returns to IDLE so an access is never repeated.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_req)  w_next_state = ST_LOW;
            ST_LOW:  if (w_last) w_next_state = ST_HIGH;
            ST_HIGH: if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: ready, counter control, and the values the pin registers
    // take on the next edge (pins are registered, so they are set one cycle
    // ahead of the cycle they describe).
    always_comb begin
        ready        = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        w_capture    = 1'b0;
        w_lat_lo     = 1'b0;
        w_lat_hi     = 1'b0;
        w_addr_nxt   = sram_addr;
        w_dq_out_nxt = sram_dq_out;
        w_oe_nxt     = 1'b0;
        w_we_n_nxt   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                ready       = ~w_req;
                w_cnt_clear = 1'b1;
                if (w_req) begin
                    w_capture    = 1'b1;
                    w_addr_nxt   = {w_idx, 1'b0};
                    w_dq_out_nxt = wdata[15:0];
                    w_oe_nxt     = w_req_write;
                    w_we_n_nxt   = ~w_req_write;
                end
            end
            ST_LOW: begin
                w_cnt_en = 1'b1;
                if (w_last) begin
                    w_lat_lo     = ~r_write;
                    w_addr_nxt   = {r_idx, 1'b1};
                    w_dq_out_nxt = r_wdata[31:16];
                    w_oe_nxt     = r_write;
                    w_we_n_nxt   = ~r_write;
                end else begin
                    // Strobe releases for the final (hold) cycle of the phase.
                    w_oe_nxt   = r_write;
                    w_we_n_nxt = ~(r_write & ~w_next_last);
                end
            end
            ST_HIGH: begin
                w_cnt_en = 1'b1;
                if (w_last) begin
                    w_lat_hi = ~r_write;
                end else begin
                    w_oe_nxt   = r_write;
                    w_we_n_nxt = ~(r_write & ~w_next_last);
                end
            end
            ST_DONE: begin
                ready       = 1'b1;
                w_cnt_clear = 1'b1;
            end
            default: begin
                w_cnt_clear = 1'b1;
            end
        endcase
    end

    // Request capture, load-data latching and SRAM pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            if (w_capture) begin
                r_write <= w_req_write;
                r_idx   <= w_idx;
                r_wdata <= wdata;
            end
            if (w_lat_lo) rdata[15:0]  <= sram_dq_in;
            if (w_lat_hi) rdata[31:16] <= sram_dq_in;
            sram_addr   <= w_addr_nxt;
            sram_dq_out <= w_dq_out_nxt;
            sram_dq_oe  <= w_oe_nxt;
            sram_we_n   <= w_we_n_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_controller
// Purpose  : Directed, table-driven self-checking bench for the SRAM access
//            controller with a behavioural 16-bit SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_access_controller;

    localparam int W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic        mem_clr = 1'b1;
    logic [15:0] mem [0:255];

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_rd  = 32'd0;

    sram_access_controller #(
        .WAIT_CYCLES (W),
        .SRAM_AW     (18),
        .BASE_ADDR   (32'd1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: writes while strobe low and bus driven, async read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = mem[sram_addr[7:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete access starting in an IDLE cycle; inputs held while stalled.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_load);
        logic [31:0] off;
        logic [16:0] idx;
        logic        ph;
        int          k;
        int          low_cnt;
        off = a - 32'd1024;
        idx = off[18:2];
        @(posedge clk); #1;
        mem_r_en = rd; mem_w_en = wr; addr = a; wdata = d;
        #1;
        check("req_ready", 64'(ready), 64'(0));
        check("rdata_hold", 64'(rdata), 64'(exp_rd));
        low_cnt = (ready == 1'b0) ? 1 : 0;
        for (int c = 1; c <= 2 * W; c++) begin
            @(posedge clk); #2;
            ph = (c > W);
            k  = (c - 1) % W;
            if (ready == 1'b0) low_cnt++;
            check("phase_addr", 64'(sram_addr), 64'({idx, ph}));
            check("phase_ctl", 64'({sram_dq_oe, sram_we_n}),
                  64'({wr, (wr ? (k == W - 1) : 1'b1)}));
            if (wr) check("phase_dq", 64'(sram_dq_out), 64'(ph ? d[31:16] : d[15:0]));
        end
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        #1;
        check("done_ready", 64'(ready), 64'(1));
        check("ready_low_cycles", 64'(low_cnt), 64'(2 * W + 1));
        check("done_ctl", 64'({sram_dq_oe, sram_we_n}), 64'(2'b01));
        if (!wr) exp_rd = exp_load;
        check("done_rdata", 64'(rdata), 64'(exp_rd));
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0};         // STR
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF};  // LDR same word
        vecs[2] = '{1'b1, 1'b1, 32'd1040, 32'h12345678, 32'h0};         // both enables: store
        vecs[3] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd2048, 32'h0,        32'h00000000};  // unwritten word
        vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 32'h0};         // below base: wraps
        vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'hA5A55A5A};

        repeat (3) @(posedge clk);
        #1; rst = 1'b0; mem_clr = 1'b0;

        // Reset state held with no requests.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            check("reset_ready", 64'(ready), 64'(1));
            check("reset_ctl", 64'({sram_dq_oe, sram_we_n}), 64'(2'b01));
            check("reset_rdata", 64'(rdata), 64'(0));
            check("reset_addr", 64'(sram_addr), 64'(0));
        end

        // Back-to-back accesses from the table.
        for (int v = 0; v < 7; v++) begin
            access(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, vecs[v].exp_load);
        end

        // Load data held while idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("idle_ready", 64'(ready), 64'(1));
            check("idle_rdata", 64'(rdata), 64'(exp_rd));
        end

        // Reset during HIGH phase cycle 2 of a store.
        @(posedge clk); #1;
        mem_w_en = 1'b1; addr = 32'd1100; wdata = 32'hCAFEF00D;
        #1;
        check("abort_req_ready", 64'(ready), 64'(0));
        for (int c = 1; c <= W + 2; c++) begin
            @(posedge clk); #2;
            check("abort_busy", 64'(ready), 64'(0));
        end
        rst = 1'b1; mem_w_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        exp_rd = 32'd0;
        check("abort_ctl", 64'({sram_dq_oe, sram_we_n}), 64'(2'b01));
        check("abort_addr", 64'(sram_addr), 64'(0));
        check("abort_dq", 64'(sram_dq_out), 64'(0));
        check("abort_rdata", 64'(rdata), 64'(0));
        check("abort_idle_ready", 64'(ready), 64'(1));
        for (int i = 0; i < 2 * W + 2; i++) begin
            @(posedge clk); #2;
            check("abort_quiet", 64'({ready, sram_we_n, sram_dq_oe}), 64'(3'b110));
        end

        // Controller is idle and usable; the store reached both halves before reset.
        access(1'b1, 1'b0, 32'd1100, 32'h0, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_access_controller.md
# sram_access_controller

Sequences LDR/STR accesses from the MEM stage onto a 16-bit external SRAM with programmable wait states. Each 32-bit word transfer is two 16-bit half-word phases. While an access is in flight, the block holds `ready` low so the pipeline freezes. It sits between the EXE/MEM pipeline register, which supplies `MEM_R_EN`/`MEM_W_EN` as decoded by the control unit, and the SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: cycles per half-word phase; legal range ≥ 2.
- `SRAM_AW`, 18: SRAM half-word address width.
- `BASE_ADDR`, 32'd1024: CPU byte address that maps to SRAM word 0.

Ports:
- `clk` input 1: single clock; all logic samples on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mem_r_en` input 1: load request.
- `mem_w_en` input 1: store request.
- `addr` input 32: CPU byte address.
- `wdata` input 32: store data.
- `rdata` output 32: load data; valid in the DONE cycle, then held.
- `ready` output 1: high means the pipeline may advance.
- `sram_addr` output SRAM_AW: half-word address.
- `sram_dq_out` output 16: write data to the pins.
- `sram_dq_in` input 16: read data from the pins.
- `sram_dq_oe` output 1: drive enable for the bidirectional data bus.
- `sram_we_n` output 1: active-low write strobe.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - No request: `ready` = 1.
  - `mem_r_en` or `mem_w_en` high: `ready` = 0 (combinational, same cycle); next state is LOW; `wait_cnt` cleared.
  - Both enables high is illegal; the access is performed as a write.
- Request capture: op, word index and wdata are captured on the IDLE→LOW edge. Inputs are ignored until the access returns to IDLE.
- Word index: `(addr − BASE_ADDR) >> 2`, modulo 32 bits, truncated to SRAM_AW−1 bits. Out-of-range addresses wrap; no error is flagged.
- LOW phase:
  - `sram_addr = {idx, 1'b0}`, `sram_dq_out = wdata[15:0]`.
  - Lasts exactly WAIT_CYCLES cycles, counted by `wait_cnt` 0..WAIT_CYCLES−1.
  - On the last cycle: reads latch `sram_dq_in` into `rdata[15:0]`; next state is HIGH.
- HIGH phase:
  - Same as LOW with `sram_addr = {idx, 1'b1}`, `sram_dq_out = wdata[31:16]`, and reads latch into `rdata[31:16]`.
  - Next state is DONE.
- Writes: `sram_dq_oe` = 1 for every cycle of LOW and HIGH. `sram_we_n` = 0 on all cycles of a phase except the last, which is the hold cycle with `sram_we_n` = 1.
- Reads: `sram_dq_oe` = 0 and `sram_we_n` = 1 throughout.
- DONE: `ready` = 1 for exactly one cycle; next state is IDLE unconditionally. The pipeline advances on this edge, so IDLE sees the next instruction's request. The same access is never repeated.
- Stores do not modify `rdata`.

## Timing
- Reset values: state IDLE, `wait_cnt` 0, `rdata` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` = 1 when no request is present.
- Request first seen in IDLE at cycle t:
  - LOW occupies t+1 .. t+W.
  - HIGH occupies t+W+1 .. t+2W.
  - DONE is at t+2W+1.
  - `ready` is low for 2W+1 cycles (t .. t+2W).
- Back-to-back requests cost one cycle in DONE and one in IDLE. There is no bubble beyond that.
- Reset mid-access: at the next edge all outputs return to reset values. There is no `ready` pulse for the aborted access and `sram_we_n` is high immediately. The SRAM may hold a partially written word.
- All SRAM pin outputs are registered; only `ready` is combinational, from state and request.

## Structure
- Shared package `mem_ctrl_pkg`: the state enum (IDLE/LOW/HIGH/DONE), the default `BASE_ADDR`, and the default `WAIT_CYCLES`.
- Sub-module `wait_counter`: a parameterised modulo-WAIT_CYCLES counter with `clear`, `en` and `last` outputs.
- The FSM, address mapping and data muxing live in `sram_access_controller`.

## Test plan
- Reset, no requests: `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0, `rdata` = 0, `sram_addr` = 0, held for 20 cycles.
- STR, `addr` = 1024+8, `wdata` = 0xDEADBEEF, W = 5:
  - `ready` low for 11 cycles.
  - `sram_addr` = 4 with data 0xBEEF, then 5 with data 0xDEAD.
  - `sram_we_n` low 4 cycles per phase.
  - One `ready` pulse.
- LDR from the same address with an SRAM model: `rdata` = 0xDEADBEEF in the DONE cycle, and held through the following IDLE.
- Both enables high: a write is performed; `sram_dq_oe` = 1 in both phases.
- Back-to-back STR then LDR: the second access starts the cycle after DONE→IDLE; total `ready`-low count is 22; each address is accessed exactly once.
- `rst` asserted in HIGH phase cycle 2 of a store: the next cycle shows `sram_we_n` = 1, `sram_dq_oe` = 0, state IDLE, and no `ready` pulse from the aborted access.
